// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Purpose : Shared constants for the binary-neural-network sequencer. Holds
//           the neuron counts, the power-on weight table and the FSM states.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package bnn_pkg;

  localparam int NUM_L1 = 8;
  localparam int NUM_L2 = 4;
  localparam int NUM_N  = NUM_L1 + NUM_L2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L2   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Weight byte per neuron, bit 7..0; entries 0..7 are layer 1, 8..11 layer 2.
  localparam logic [7:0] DEFAULT_W [NUM_N] = '{
    8'b10100000, 8'b01000001, 8'b01111010, 8'b00011000,
    8'b11101101, 8'b10110111, 8'b01100111, 8'b00111010,
    8'b11111001, 8'b01100010, 8'b11110111, 8'b00001111
  };

endpackage

// File: rtl/bnn_sequencer_if.sv
// ---------------------------------------------------------------------------
// bnn_sequencer_if
// Purpose : Bundles the weight-load, inference-request and result signals of
//           the BNN sequencer.
// Signals : load_en/load_nibble  weight nibble strobe and data (low nibble first)
//           start/in_vec         inference request and input vector
//           busy/done            inference in progress / one-cycle result pulse
//           l1_out/l2_out        layer-1 and layer-2 neuron results
//           load_done            pulse after the last neuron's byte is written
// Modports: master drives requests, slave (the sequencer) drives results.
// ---------------------------------------------------------------------------
interface bnn_sequencer_if #(
  parameter int L1_W = bnn_pkg::NUM_L1,
  parameter int L2_W = bnn_pkg::NUM_L2
);

  logic            load_en;
  logic [3:0]      load_nibble;
  logic            start;
  logic [L1_W-1:0] in_vec;
  logic            busy;
  logic            done;
  logic [L1_W-1:0] l1_out;
  logic [L2_W-1:0] l2_out;
  logic            load_done;

  modport master (
    output load_en, load_nibble, start, in_vec,
    input  busy, done, l1_out, l2_out, load_done
  );

  modport slave (
    input  load_en, load_nibble, start, in_vec,
    output busy, done, l1_out, l2_out, load_done
  );

endinterface

// File: rtl/bnn_xnor_pop8.sv
// ---------------------------------------------------------------------------
// bnn_xnor_pop8
// Purpose : Combinational XNOR-popcount: counts the bit positions where the
//           input vector agrees with the weight byte (0..8).
// Ports   : i_x   8-bit binary input vector
//           i_w   8-bit weight byte
//           o_sum 4-bit agreement count
// ---------------------------------------------------------------------------
module bnn_xnor_pop8 (
  input  logic [7:0] i_x,
  input  logic [7:0] i_w,
  output logic [3:0] o_sum
);

  logic [7:0] w_match;

  assign w_match = ~(i_x ^ i_w);

  always_comb begin
    o_sum = '0;
    for (int b = 0; b < 8; b++) begin
      o_sum = o_sum + 4'(w_match[b]);
    end
  end

endmodule

// File: rtl/bnn_sequencer.sv
// ---------------------------------------------------------------------------
// bnn_sequencer
// Purpose : Two-layer binary neural network (8 + 4 neurons) evaluated with a
//           single shared XNOR-popcount unit, one neuron per clock. Weights
//           are reloadable a nibble at a time while idle.
// Ports   : clk    rising-edge clock
//           reset  asynchronous, active-high
//           bus    bnn_sequencer_if.slave (load, start, results, status)
// Timing  : start accepted at edge 0 -> neurons evaluated on edges 1..12,
//           results and done presented after edge 13.
// ---------------------------------------------------------------------------
module bnn_sequencer #(
  parameter int THRESHOLD = 6,
  parameter int NUM_L1    = 8,
  parameter int NUM_L2    = 4
) (
  input logic             clk,
  input logic             reset,
  bnn_sequencer_if.slave  bus
);

  import bnn_pkg::*;

  localparam logic [3:0] THR      = 4'(THRESHOLD);
  localparam logic [3:0] LAST_L1  = 4'(NUM_L1 - 1);
  localparam logic [3:0] LAST_ALL = 4'(NUM_L1 + NUM_L2 - 1);

  state_t                  r_state;
  logic [3:0]              r_idx;
  logic [NUM_L1-1:0]       r_in_vec;
  logic [NUM_N-1:0]        r_scratch;
  logic [7:0]              r_weights [NUM_N];
  logic                    r_half;
  logic [3:0]              r_temp;
  logic [3:0]              r_load_ptr;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_load_done;
  logic [NUM_L1-1:0]       r_l1_out;
  logic [NUM_L2-1:0]       r_l2_out;

  logic [7:0]              w_x;
  logic [3:0]              w_sum;
  logic                    w_fire;

  // Layer 2 consumes the freshly computed layer-1 bits instead of in_vec.
  assign w_x    = (r_state == S_L2) ? r_scratch[NUM_L1-1:0] : r_in_vec;
  assign w_fire = (w_sum >= THR);

  bnn_xnor_pop8 u_pop (
    .i_x   (w_x),
    .i_w   (r_weights[r_idx]),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_in_vec    <= '0;
      r_scratch   <= '0;
      r_half      <= 1'b0;
      r_temp      <= '0;
      r_load_ptr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_load_done <= 1'b0;
      r_l1_out    <= '0;
      r_l2_out    <= '0;
      for (int n = 0; n < NUM_N; n++) begin
        r_weights[n] <= DEFAULT_W[n];
      end
    end else begin
      r_done      <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // start has priority; a nibble offered in the same cycle is dropped.
          if (bus.start) begin
            r_in_vec <= bus.in_vec;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_L1;
          end else if (bus.load_en) begin
            if (!r_half) begin
              r_temp <= bus.load_nibble;
              r_half <= 1'b1;
            end else begin
              r_weights[r_load_ptr] <= {bus.load_nibble, r_temp};
              r_half                <= 1'b0;
              if (r_load_ptr == LAST_ALL) begin
                r_load_ptr  <= '0;
                r_load_done <= 1'b1;
              end else begin
                r_load_ptr <= r_load_ptr + 4'd1;
              end
            end
          end
        end
        S_L1: begin
          r_scratch[r_idx] <= w_fire;
          r_idx            <= r_idx + 4'd1;
          if (r_idx == LAST_L1) r_state <= S_L2;
        end
        S_L2: begin
          r_scratch[r_idx] <= w_fire;
          r_idx            <= r_idx + 4'd1;
          if (r_idx == LAST_ALL) r_state <= S_DONE;
        end
        S_DONE: begin
          // Results are published only here so they stay stable while busy.
          r_done   <= 1'b1;
          r_l1_out <= r_scratch[NUM_L1-1:0];
          r_l2_out <= r_scratch[NUM_N-1:NUM_L1];
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.l1_out    = r_l1_out;
  assign bus.l2_out    = r_l2_out;
  assign bus.load_done = r_load_done;

endmodule
